// File: rtl/q3_debounce_sync.sv
// Two-or-more flop synchroniser feeding a stability-count debouncer with edge pulses.
// Optional toggle-on-press output enabled by defining DEBOUNCE_TOGGLE_EN.
module q3_debounce_sync #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 50000,
    parameter int CNT_W         = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall,
    output logic toggle
);

    typedef enum logic [1:0] {
        IDLE_LO,
        WAIT_HI,
        IDLE_HI,
        WAIT_LO
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("q3_debounce_sync: SYNC_STAGES must be >= 2");
    end
    if (STABLE_CYCLES < 2) begin : g_bad_stable
        $error("q3_debounce_sync: STABLE_CYCLES must be >= 2");
    end
    if ((64'd1 << CNT_W) <= 64'(STABLE_CYCLES)) begin : g_bad_cnt
        $error("q3_debounce_sync: CNT_W too narrow for STABLE_CYCLES");
    end

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic                   done;

    // din goes straight into the first flop; nothing combinational ahead of it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], din};
        end
    end

    assign s    = sync[SYNC_STAGES-1];
    assign done = (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE_LO;
            cnt   <= '0;
            dout  <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            unique case (state)
                IDLE_LO: begin
                    if (s) begin
                        state <= WAIT_HI;
                        cnt   <= CNT_W'(1);
                    end else begin
                        cnt <= '0;
                    end
                end
                WAIT_HI: begin
                    if (!s) begin
                        state <= IDLE_LO;
                        cnt   <= '0;
                    end else if (done) begin
                        state <= IDLE_HI;
                        cnt   <= '0;
                        dout  <= 1'b1;
                        rise  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                IDLE_HI: begin
                    if (!s) begin
                        state <= WAIT_LO;
                        cnt   <= CNT_W'(1);
                    end else begin
                        cnt <= '0;
                    end
                end
                WAIT_LO: begin
                    if (s) begin
                        state <= IDLE_HI;
                        cnt   <= '0;
                    end else if (done) begin
                        state <= IDLE_LO;
                        cnt   <= '0;
                        dout  <= 1'b0;
                        fall  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE_LO;
                    cnt   <= '0;
                    dout  <= 1'b0;
                end
            endcase
        end
    end

`ifdef DEBOUNCE_TOGGLE_EN
    // flips on the same edge that launches the rise pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            toggle <= 1'b0;
        end else if (state == WAIT_HI && s && done) begin
            toggle <= ~toggle;
        end
    end
`else
    assign toggle = 1'b0;
`endif

endmodule
